// File: rtl/snake_pkg.sv
// snake_pkg: shared definitions for the snake pacing logic.
//   TICK_W      width of the game-tick counter and period values
//   LEFT/RIGHT/UP/DOWN  2-bit direction codes
//   is_opposite(a,b)    1 when a and b are a reversing pair (LEFT/RIGHT, UP/DOWN)
package snake_pkg;

    localparam int TICK_W = 24;

    localparam logic [1:0] LEFT  = 2'b00;
    localparam logic [1:0] RIGHT = 2'b01;
    localparam logic [1:0] UP    = 2'b10;
    localparam logic [1:0] DOWN  = 2'b11;

    // Reversing pairs share the axis bit [1] and differ in the sense bit [0].
    function automatic logic is_opposite(input logic [1:0] a, input logic [1:0] b);
        return (a[1] == b[1]) && (a[0] != b[0]);
    endfunction

endpackage

// File: rtl/snake_dir_fifo.sv
// snake_dir_fifo: small DEPTH x 2-bit FIFO of pending snake directions.
// Ports:
//   Clk, Reset  clock, asynchronous active-high reset (pointers only)
//   flush       synchronous clear; wins over push/pop
//   push        write push_data at the tail (caller guarantees room, or a
//               same-cycle pop when full)
//   pop         advance the head (caller guarantees non-empty)
//   head_data   oldest entry (next direction to apply)
//   tail_data   newest entry (reference for accept/reject of new presses)
//   full, empty occupancy flags
// DEPTH must be a power of two, >= 2.
module snake_dir_fifo #(
    parameter int DEPTH = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       flush,
    input  logic       push,
    input  logic [1:0] push_data,
    input  logic       pop,
    output logic [1:0] head_data,
    output logic [1:0] tail_data,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]   wr_ptr_reg;
    logic [AW:0]   rd_ptr_reg;
    logic [1:0]    mem_reg [DEPTH];
    logic [AW-1:0] tail_idx;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge Clk) begin
                if (push && !flush && (wr_ptr_reg[AW-1:0] == AW'(gi))) begin
                    mem_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    assign tail_idx  = wr_ptr_reg[AW-1:0] - AW'(1);
    assign head_data = mem_reg[rd_ptr_reg[AW-1:0]];
    assign tail_data = mem_reg[tail_idx];
    assign empty     = (wr_ptr_reg == rd_ptr_reg);
    assign full      = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                       (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

endmodule

// File: rtl/snake_tick_ctrl.sv
// snake_tick_ctrl: game-pacing controller for the snake core.
// Divides Clk into game ticks, issues one Step pulse per tick together with
// the direction for that step, queues accepted button presses, and handles
// pause.
// Ports:
//   Clk, Reset               clock, asynchronous active-high reset
//   Left/Right/Up/Down       debounced button levels (rising edge = press)
//   Pause                    level; rising edge toggles Paused
//   Run                      high while the core is playing
//   Length[3:0]              snake length (speed-up build only)
//   Step                     one-cycle advance pulse
//   Dir[1:0]                 direction to apply (LEFT=00 RIGHT=01 UP=10 DOWN=11)
//   Paused                   pause state
//   Drop                     one-cycle pulse: accepted press lost, FIFO full
// Build option: define SNAKE_SPEEDUP_EN to shorten the tick period as the
// snake grows: period = max(MIN_DIV, TICK_DIV - Length*SPEED_STEP).
module snake_tick_ctrl
    import snake_pkg::*;
#(
    parameter logic [TICK_W-1:0] TICK_DIV   = 24'd6250000,
    parameter int                DEPTH      = 2,
    parameter logic [TICK_W-1:0] SPEED_STEP = 24'd250000,
    parameter logic [TICK_W-1:0] MIN_DIV    = 24'd1250000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Left,
    input  logic       Right,
    input  logic       Up,
    input  logic       Down,
    input  logic       Pause,
    input  logic       Run,
    input  logic [3:0] Length,
    output logic       Step,
    output logic [1:0] Dir,
    output logic       Paused,
    output logic       Drop
);

    logic [3:0]        btn_prev_reg;
    logic [3:0]        btn_edge;
    logic              pause_prev_reg;
    logic              pause_edge;
    logic              paused_reg, paused_next;
    logic              step_reg, step_next;
    logic              drop_reg, drop_next;
    logic [1:0]        dir_reg, dir_next;
    logic [TICK_W-1:0] count_reg, count_next;
    logic [TICK_W-1:0] period;
    logic              press_valid;
    logic [1:0]        press_dir;
    logic [1:0]        ref_dir;
    logic              accept;
    logic              count_en;
    logic              terminal;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [1:0]        fifo_head, fifo_tail;

    // Button vector ordered by priority: Left highest, Down lowest.
    assign btn_edge   = {Left, Right, Up, Down} & ~btn_prev_reg;
    assign pause_edge = Pause & ~pause_prev_reg;

`ifdef SNAKE_SPEEDUP_EN
    logic [TICK_W+3:0] reduce;
    logic [TICK_W-1:0] sat_div;
    logic [TICK_W-1:0] period_calc;
    logic [TICK_W-1:0] period_reg;

    // Extra 4 bits hold the full Length*SPEED_STEP product before saturating.
    always_comb begin
        reduce = (TICK_W+4)'(Length) * (TICK_W+4)'(SPEED_STEP);
        if (reduce >= (TICK_W+4)'(TICK_DIV)) begin
            sat_div = '0;
        end else begin
            sat_div = TICK_DIV - reduce[TICK_W-1:0];
        end
        period_calc = (sat_div < MIN_DIV) ? MIN_DIV : sat_div;
    end

    // Period is only re-sampled when the counter restarts, so a growing
    // snake never cuts short the tick already in progress.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            period_reg <= TICK_DIV;
        end else if (!Run || terminal) begin
            period_reg <= period_calc;
        end
    end

    assign period = period_reg;
`else
    logic unused_cfg;

    assign period     = TICK_DIV;
    assign unused_cfg = ^{Length, SPEED_STEP, MIN_DIV};
`endif

    always_comb begin
        press_valid = Run && !paused_reg && (btn_edge != 4'b0000);
        if (btn_edge[3])      press_dir = LEFT;
        else if (btn_edge[2]) press_dir = RIGHT;
        else if (btn_edge[1]) press_dir = UP;
        else                  press_dir = DOWN;

        // New presses are judged against the last queued turn, not the
        // current heading, so two quick turns compose correctly.
        ref_dir = fifo_empty ? dir_reg : fifo_tail;
        accept  = press_valid && (press_dir != ref_dir) &&
                  !is_opposite(press_dir, ref_dir);

        // A pause edge freezes the counter in the same cycle, which is what
        // lets a pause on the terminal count suppress the Step.
        count_en  = Run && !paused_reg && !pause_edge;
        terminal  = count_en && (count_reg == period - TICK_W'(1));
        fifo_pop  = terminal && !fifo_empty;
        fifo_push = accept && (!fifo_full || fifo_pop);

        paused_next = paused_reg;
        step_next   = 1'b0;
        drop_next   = 1'b0;
        dir_next    = dir_reg;
        count_next  = count_reg;

        if (!Run) begin
            paused_next = 1'b0;
            dir_next    = RIGHT;
            count_next  = '0;
        end else begin
            paused_next = paused_reg ^ pause_edge;
            step_next   = terminal;
            drop_next   = accept && fifo_full && !fifo_pop;
            if (terminal) begin
                count_next = '0;
            end else if (count_en) begin
                count_next = count_reg + TICK_W'(1);
            end
            if (fifo_pop) begin
                dir_next = fifo_head;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            btn_prev_reg   <= '0;
            pause_prev_reg <= 1'b0;
            paused_reg     <= 1'b0;
            step_reg       <= 1'b0;
            drop_reg       <= 1'b0;
            dir_reg        <= RIGHT;
            count_reg      <= '0;
        end else begin
            btn_prev_reg   <= {Left, Right, Up, Down};
            pause_prev_reg <= Pause;
            paused_reg     <= paused_next;
            step_reg       <= step_next;
            drop_reg       <= drop_next;
            dir_reg        <= dir_next;
            count_reg      <= count_next;
        end
    end

    snake_dir_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .Clk      (Clk),
        .Reset    (Reset),
        .flush    (!Run),
        .push     (fifo_push),
        .push_data(press_dir),
        .pop      (fifo_pop),
        .head_data(fifo_head),
        .tail_data(fifo_tail),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign Step   = step_reg;
    assign Dir    = dir_reg;
    assign Paused = paused_reg;
    assign Drop   = drop_reg;

endmodule

// File: tb/tb_snake_tick_ctrl.sv
// tb_snake_tick_ctrl: directed scenarios plus randomized play, every cycle
// compared against a queue-based reference of the pacing rules.
module tb_snake_tick_ctrl;

    localparam int TB_TICK  = 4;
    localparam int TB_DEPTH = 2;
`ifdef SNAKE_SPEEDUP_EN
    localparam int TB_STEP  = 1;
    localparam int TB_MIN   = 2;
`endif

    localparam logic [3:0] B_NONE = 4'b0000;
    localparam logic [3:0] B_L    = 4'b1000;
    localparam logic [3:0] B_R    = 4'b0100;
    localparam logic [3:0] B_U    = 4'b0010;
    localparam logic [3:0] B_D    = 4'b0001;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Left, Right, Up, Down, Pause, Run;
    logic [3:0] Length;
    logic       Step;
    logic [1:0] Dir;
    logic       Paused;
    logic       Drop;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state
    logic [1:0] m_q[$];
    logic [1:0] m_dir;
    bit         m_paused, m_step, m_drop, m_prev_pause;
    logic [3:0] m_prev_btn;
    int         m_cnt, m_period;
    logic [3:0] cur_len;

    snake_tick_ctrl #(
        .TICK_DIV  (24'd4),
        .DEPTH     (2),
        .SPEED_STEP(24'd1),
        .MIN_DIV   (24'd2)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Left  (Left),
        .Right (Right),
        .Up    (Up),
        .Down  (Down),
        .Pause (Pause),
        .Run   (Run),
        .Length(Length),
        .Step  (Step),
        .Dir   (Dir),
        .Paused(Paused),
        .Drop  (Drop)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

`ifdef SNAKE_SPEEDUP_EN
    function automatic int calc_period(input int len);
        int p;
        p = TB_TICK - len * TB_STEP;
        if (p < TB_MIN) p = TB_MIN;
        return p;
    endfunction
`endif

    task automatic model_reset();
        m_q.delete();
        m_dir        = 2'b01;
        m_paused     = 1'b0;
        m_step       = 1'b0;
        m_drop       = 1'b0;
        m_prev_pause = 1'b0;
        m_prev_btn   = 4'b0000;
        m_cnt        = 0;
        m_period     = TB_TICK;
    endtask

    task automatic refresh_period(input logic [3:0] len);
`ifdef SNAKE_SPEEDUP_EN
        m_period = calc_period(int'(len));
`else
        m_period = TB_TICK;
        if (len > 4'd15) m_period = 0;
`endif
    endtask

    // One clock of game rules, applied to the inputs held for that clock.
    task automatic model_step(input logic [3:0] btn, input logic p, input logic r,
                              input logic [3:0] len);
        logic [3:0] e;
        bit         pe, have_press, accept, active;
        logic [1:0] pd, refd;
        e            = btn & ~m_prev_btn;
        pe           = p && !m_prev_pause;
        m_prev_btn   = btn;
        m_prev_pause = p;
        m_step       = 1'b0;
        m_drop       = 1'b0;
        if (!r) begin
            m_q.delete();
            m_dir    = 2'b01;
            m_paused = 1'b0;
            m_cnt    = 0;
            refresh_period(len);
            return;
        end
        have_press = !m_paused && (e != 4'b0000);
        pd = e[3] ? 2'b00 : e[2] ? 2'b01 : e[1] ? 2'b10 : 2'b11;
        refd = (m_q.size() > 0) ? m_q[$] : m_dir;
        accept = have_press && (pd != refd) &&
                 !({pd, refd} inside {4'b0001, 4'b0100, 4'b1011, 4'b1110});
        active = !m_paused && !pe;
        if (active) begin
            if (m_cnt == m_period - 1) begin
                m_step = 1'b1;
                m_cnt  = 0;
                if (m_q.size() > 0) m_dir = m_q.pop_front();
                refresh_period(len);
            end else begin
                m_cnt++;
            end
        end
        if (accept) begin
            if (m_q.size() < TB_DEPTH) m_q.push_back(pd);
            else                       m_drop = 1'b1;
        end
        if (pe) m_paused = !m_paused;
    endtask

    task automatic drive_cycle(input logic [3:0] btn, input logic p, input logic r,
                               input logic [3:0] len);
        {Left, Right, Up, Down} = btn;
        Pause  = p;
        Run    = r;
        Length = len;
        model_step(btn, p, r, len);
        @(negedge Clk);
        check("step",   32'(Step),   32'(m_step));
        check("dir",    32'(Dir),    32'(m_dir));
        check("paused", 32'(Paused), 32'(m_paused));
        check("drop",   32'(Drop),   32'(m_drop));
        if (Step || Drop)
            $display("txn t=%0t step=%b dir=%b drop=%b paused=%b", $time, Step, Dir, Drop, Paused);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(B_NONE, 1'b0, 1'b1, cur_len);
    endtask

    // Bring the reference to the start of a fresh tick (bounded).
    task automatic sync_tick();
        for (int i = 0; i < 16 && m_cnt != 0; i++) idle(1);
        check("sync_bound", 32'(m_cnt), 32'd0);
    endtask

    task automatic do_reset();
        {Left, Right, Up, Down} = B_NONE;
        Pause  = 1'b0;
        Run    = 1'b0;
        #2;
        Reset = 1'b1;
        #1;
        check("rst_step",   32'(Step),   32'd0);
        check("rst_dir",    32'(Dir),    32'd1);
        check("rst_paused", 32'(Paused), 32'd0);
        check("rst_drop",   32'(Drop),   32'd0);
        model_reset();
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1;
        {Left, Right, Up, Down} = B_NONE;
        Pause   = 1'b0;
        Run     = 1'b0;
        Length  = 4'd1;
        cur_len = 4'd1;
        model_reset();
        #1;
        check("rst_step",   32'(Step),   32'd0);
        check("rst_dir",    32'(Dir),    32'd1);
        check("rst_paused", 32'(Paused), 32'd0);
        check("rst_drop",   32'(Drop),   32'd0);
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;

        // Settle Run low once so the period reflects Length.
        drive_cycle(B_NONE, 1'b0, 1'b0, cur_len);

        // Free-running ticks, direction stays RIGHT.
        idle(12);

        // Reversal against RIGHT is rejected.
        sync_tick();
        drive_cycle(B_L, 1'b0, 1'b1, cur_len);
        idle(6);

        // Two quick turns inside one tick.
        sync_tick();
        drive_cycle(B_U, 1'b0, 1'b1, cur_len);
        drive_cycle(B_NONE, 1'b0, 1'b1, cur_len);
        drive_cycle(B_L, 1'b0, 1'b1, cur_len);
        idle(8);

        // Three turns: third overflows the two-entry queue.
        drive_cycle(B_NONE, 1'b0, 1'b0, cur_len);
        sync_tick();
        drive_cycle(B_U, 1'b0, 1'b1, cur_len);
        drive_cycle(B_L, 1'b0, 1'b1, cur_len);
        drive_cycle(B_D, 1'b0, 1'b1, cur_len);
        idle(8);

        // Simultaneous presses: priority pick.
        sync_tick();
        drive_cycle(B_U | B_D | B_R, 1'b0, 1'b1, cur_len);
        idle(6);

        // Pause mid-tick, a press while paused, then resume.
        sync_tick();
        idle(2);
        drive_cycle(B_NONE, 1'b1, 1'b1, cur_len);
        drive_cycle(B_NONE, 1'b0, 1'b1, cur_len);
        drive_cycle(B_L, 1'b0, 1'b1, cur_len);
        idle(3);
        drive_cycle(B_NONE, 1'b1, 1'b1, cur_len);
        idle(6);

        // Pause on the terminal count cycle.
        sync_tick();
        idle(3);
        drive_cycle(B_NONE, 1'b1, 1'b1, cur_len);
        idle(2);
        drive_cycle(B_NONE, 1'b1, 1'b1, cur_len);
        idle(4);

        // Length change mid-tick, then Run low mid-tick with a queued turn.
        drive_cycle(B_NONE, 1'b0, 1'b0, cur_len);
        drive_cycle(B_NONE, 1'b0, 1'b0, cur_len);
        idle(7);
        cur_len = 4'd3;
        idle(9);
        sync_tick();
        drive_cycle(B_U, 1'b0, 1'b1, cur_len);
        drive_cycle(B_NONE, 1'b0, 1'b0, cur_len);
        idle(6);

        // Asynchronous reset in the middle of play.
        idle(3);
        do_reset();
        idle(6);

        // Randomized play.
        for (int i = 0; i < 1500; i++) begin
            logic [3:0] b;
            logic       p, r;
            b = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : B_NONE;
            p = ($urandom_range(0, 29) == 0);
            r = ($urandom_range(0, 49) != 0);
            if ((i % 64) == 0) cur_len = 4'($urandom_range(0, 15));
            drive_cycle(b, p, r, cur_len);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
